mem_bist_ctrl: RTL and testbench
================================

# mem_bist_ctrl

Built-in self-test initiator for the single-port synchronous memory. It drives the memory's write-enable, write-data and address lines and consumes its registered read-data output. It runs a fixed four-phase march (write pattern, read/compare, write inverse, read/compare) over every address and reports pass/fail, an error count and the first failing location. It sits beside the memory, and on `start` it takes over the memory port from the functional master.

## Interface
Parameters:
- `MEM_DEPTH`, 32: number of words tested; addresses 0..MEM_DEPTH-1.
- `DATA_WIDTH`, 32: memory word width.
- `ADDR_WIDTH`, 5: memory address width; must satisfy 2^ADDR_WIDTH >= MEM_DEPTH.
- `SEED`, 32'hA5A5A5A5: base pattern, DATA_WIDTH bits.
- `ERR_WIDTH`, 8: width of the error counter.

Ports:
- `clk` in 1: the block's single clock; all logic updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin a test; sampled only in IDLE.
- `mem_we` out 1: memory write enable.
- `mem_din` out DATA_WIDTH: memory write data.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_rdata` in DATA_WIDTH: memory registered read data; valid the cycle after an address is presented with `mem_we`=0.
- `busy` out 1: test in progress.
- `done` out 1: one-cycle pulse at test end.
- `pass` out 1: 1 if the last completed test had zero mismatches.
- `err_count` out ERR_WIDTH: mismatches in the current or last test; saturates at all-ones.
- `fail_valid` out 1: a first failure has been captured.
- `fail_addr` out ADDR_WIDTH: address of the first mismatch.
- `fail_data` out DATA_WIDTH: data read at the first mismatch.

## Operation
- Pattern definition:
  - P(a) = SEED XOR zero-extended a.
  - Phase-1 data is ~P(a).
- States:
  - IDLE: on `start`=1, clear `err_count`, `pass`, `fail_valid`, `fail_addr`, `fail_data`, then go to WR0.
  - WR0: one address per cycle, a = 0..MEM_DEPTH-1, with `mem_we`=1 and `mem_din`=P(a). After a = MEM_DEPTH-1, go to RD0.
  - RD0: issue a = 0..MEM_DEPTH-1 with `mem_we`=0. Each cycle compares `mem_rdata` against the expected value of the address issued the previous cycle; a registered expected/address pipeline holds that value. One extra drain cycle performs the last compare with no new issue; `mem_we`=0 and `mem_addr` holds. Then go to WR1.
  - WR1: as WR0, with `mem_din`=~P(a).
  - RD1: as RD0, comparing against ~P(a). Then go to DONE.
  - DONE: `done`=1 for exactly one cycle. `pass` is set to (`err_count`==0) including the final compare, then go to IDLE.
- On a mismatch:
  - `err_count` increments, saturating.
  - If `fail_valid`=0, capture `fail_addr` and `fail_data`, and set `fail_valid`=1.
  - Compares happen only in RD0/RD1 and their drain cycles.
- Status retention: `pass`, `err_count` and the fail fields hold after DONE until the next accepted `start`.
- `start` while busy: ignored.
- Port outputs outside WR/RD states: `mem_we`=0, `mem_din`=0, `mem_addr`=0.
- `busy` is 1 in WR0/RD0/WR1/RD1 and 0 in IDLE/DONE.
- Address counter: width ADDR_WIDTH. It resets to 0 at each phase entry and never exceeds MEM_DEPTH-1, so it does not wrap when MEM_DEPTH < 2^ADDR_WIDTH.

## Timing
- All outputs are registered.
- Reset values: `mem_we`=0, `mem_din`=0, `mem_addr`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_addr`=0, `fail_data`=0. State is IDLE.
- Cycle numbering: `start` is sampled high at edge 0.
  - Cycle 1: first WR0 write (`mem_we`=1, `mem_addr`=0).
  - Phase lengths: WR0 = D cycles, RD0 = D+1, WR1 = D, RD1 = D+1, where D = MEM_DEPTH.
  - `busy` is high for 4D+2 cycles.
  - `done` is high in cycle 4D+3; `pass` is valid from that cycle.
  - For D=32: `busy` covers cycles 1..130 and `done` is in cycle 131.
- Read latency: address k is issued in cycle n and `mem_rdata` for k is compared in cycle n+1.
- Write-to-read: the first read of a phase is issued the cycle after the last write of the preceding write phase.
- `rst`=1 at any point, including mid-phase: the next edge forces IDLE and all reset values. `mem_we` drops the same edge. No `done` pulse is produced.
- `start` and `rst` both high: `rst` wins.

## Test plan
- Fault-free memory, D=32, SEED=32'hA5A5A5A5, pulse `start`:
  - `busy` cycles 1..130, `done` in cycle 131.
  - `pass`=1, `err_count`=0, `fail_valid`=0.
  - `mem_we` high for exactly 64 cycles.
  - Write at address 3 in WR0 carries 32'hA5A5A5A6; in WR1 it carries 32'h5A5A5A59.
- Memory with bit 0 stuck-at-1 at address 7:
  - `err_count`=1, `fail_addr`=7, `fail_data`=32'hA5A5A5A3, `fail_valid`=1, `pass`=0.
  - The RD1 read of 32'h5A5A5A5D matches and is not counted.
- Memory that drops all writes and reads 0, with ERR_WIDTH=4:
  - `err_count` saturates at 15, `fail_addr`=0, `fail_data`=0, `pass`=0.
- Assert `rst` in cycle 40 (inside RD0):
  - Next cycle all outputs are at reset values and `mem_we`=0.
  - No `done` pulse.
  - A later `start` runs a full clean test with `pass`=1.
- Pulse `start` again in cycles 10 and 100:
  - No restart; `done` still in cycle 131.
  - Then pulse `start` in cycle 135: `busy` rises in cycle 136, and status is cleared in that same cycle.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// March-style BIST initiator for a single-port synchronous memory: write P, read/compare P,
// write ~P, read/compare ~P, then report pass, error count and the first failing location.
module mem_bist_ctrl #(
   parameter int                    MEM_DEPTH  = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 5,
   parameter logic [DATA_WIDTH-1:0] SEED       = 32'hA5A5A5A5,
   parameter int                    ERR_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_WIDTH-1:0]  err_count,
   output logic                  fail_valid,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data
);

   typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr, addr_n;
   logic                  drain, drain_n;
   logic                  wr_n, act_n;
   logic                  cmp_vld;
   logic [ADDR_WIDTH-1:0] cmp_addr;
   logic [DATA_WIDTH-1:0] cmp_exp;
   logic                  mismatch;
   logic [ERR_WIDTH-1:0]  err_n;

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
      return SEED ^ DATA_WIDTH'(a);
   endfunction

   // drain is the extra read-phase cycle that retires the last compare without a new issue
   always_comb begin
      state_n = state;
      addr_n  = addr;
      drain_n = drain;
      case (state)
         IDLE: if (start) begin
            state_n = WR0;
            addr_n  = '0;
         end
         WR0, WR1: if (addr == LAST) begin
            state_n = (state == WR0) ? RD0 : RD1;
            addr_n  = '0;
         end else begin
            addr_n = addr + 1'b1;
         end
         RD0, RD1: if (drain) begin
            state_n = (state == RD0) ? WR1 : DONE;
            addr_n  = '0;
            drain_n = 1'b0;
         end else if (addr == LAST) begin
            drain_n = 1'b1;
         end else begin
            addr_n = addr + 1'b1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign wr_n     = (state_n == WR0) || (state_n == WR1);
   assign act_n    = wr_n || (state_n == RD0) || (state_n == RD1);
   assign mismatch = cmp_vld && (mem_rdata != cmp_exp);
   assign err_n    = (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;

   // Port outputs are registered from next-state values so they line up with the phase they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         addr       <= '0;
         drain      <= 1'b0;
         mem_we     <= 1'b0;
         mem_din    <= '0;
         mem_addr   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cmp_vld    <= 1'b0;
         cmp_addr   <= '0;
         cmp_exp    <= '0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_addr  <= '0;
         fail_data  <= '0;
      end else begin
         state    <= state_n;
         addr     <= addr_n;
         drain    <= drain_n;
         mem_we   <= wr_n;
         mem_addr <= act_n ? addr_n : '0;
         mem_din  <= (state_n == WR0) ? pat(addr_n) :
                     (state_n == WR1) ? ~pat(addr_n) : '0;
         busy     <= act_n;
         done     <= (state_n == DONE);
         // expected value for the address issued this cycle, compared when its read data returns
         cmp_vld  <= ((state == RD0) || (state == RD1)) && !drain;
         cmp_addr <= addr;
         cmp_exp  <= (state == RD1) ? ~pat(addr) : pat(addr);
         if (state == IDLE && start) begin
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
         end else begin
            err_count <= err_n;
            if (mismatch && !fail_valid) begin
               fail_valid <= 1'b1;
               fail_addr  <= cmp_addr;
               fail_data  <= mem_rdata;
            end
            if (state_n == DONE) pass <= (err_n == '0);
         end
      end
   end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl: behavioural memory with optional stuck bit, plus a second
// instance (ERR_WIDTH=4) wired to a memory that always reads zero.
module tb_mem_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst, start;
   logic        stuck_en;
   logic [31:0] mem [32];
   logic [31:0] rdata1;
   logic [31:0] rdata2 = 32'h0;

   logic        we1, busy1, done1, pass1, fv1;
   logic [31:0] din1, fdata1;
   logic [4:0]  addr1, faddr1;
   logic [7:0]  err1;

   logic        we2, busy2, done2, pass2, fv2;
   logic [31:0] din2, fdata2;
   logic [4:0]  addr2, faddr2;
   logic [3:0]  err2;

   int vectors = 0;
   int miscompares = 0;

   logic        busy_h [0:199];
   logic        done_h [0:199];
   logic        we_h   [0:199];
   logic        pass_h [0:199];
   logic        fv_h   [0:199];
   logic [7:0]  err_h  [0:199];
   logic [4:0]  addr_h [0:199];
   logic [31:0] din_h  [0:199];

   always #5 clk = ~clk;

   mem_bist_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_we(we1), .mem_din(din1), .mem_addr(addr1), .mem_rdata(rdata1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .fail_addr(faddr1), .fail_data(fdata1)
   );

   mem_bist_ctrl #(.ERR_WIDTH(4)) dut_sat (
      .clk(clk), .rst(rst), .start(start),
      .mem_we(we2), .mem_din(din2), .mem_addr(addr2), .mem_rdata(rdata2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_valid(fv2), .fail_addr(faddr2), .fail_data(fdata2)
   );

   // registered-read memory; the stuck fault forces bit 0 high when address 7 is read
   always @(posedge clk) begin
      if (we1) mem[addr1] <= din1;
      rdata1 <= (stuck_en && addr1 == 5'd7) ? (mem[addr1] | 32'h1) : mem[addr1];
   end

   // Cycle k is the period after edge k-1; start/rst driven in cycle k are sampled at edge k.
   task automatic observe(input int ncyc, input int s0, input int s1, input int s2, input int s3,
                          input int rc);
      for (int k = 0; k <= ncyc; k++) begin
         @(negedge clk);
         if (k > 0) begin
            busy_h[k] = busy1; done_h[k] = done1; we_h[k] = we1; pass_h[k] = pass1;
            fv_h[k] = fv1; err_h[k] = err1; addr_h[k] = addr1; din_h[k] = din1;
         end
         start = (k == s0 || k == s1 || k == s2 || k == s3);
         rst   = (k == rc);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; stuck_en = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (we1 !== 1'b0) begin miscompares++; $display("FAIL rst_we got %0h exp 0", we1); end
      vectors++; if (din1 !== 32'h0) begin miscompares++; $display("FAIL rst_din got %0h exp 0", din1); end
      vectors++; if (addr1 !== 5'h0) begin miscompares++; $display("FAIL rst_addr got %0h exp 0", addr1); end
      vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0h exp 0", busy1); end
      vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL rst_done got %0h exp 0", done1); end
      vectors++; if (pass1 !== 1'b0) begin miscompares++; $display("FAIL rst_pass got %0h exp 0", pass1); end
      vectors++; if (err1 !== 8'h0) begin miscompares++; $display("FAIL rst_err got %0h exp 0", err1); end
      vectors++; if (fv1 !== 1'b0) begin miscompares++; $display("FAIL rst_fv got %0h exp 0", fv1); end
      vectors++; if (faddr1 !== 5'h0) begin miscompares++; $display("FAIL rst_faddr got %0h exp 0", faddr1); end
      vectors++; if (fdata1 !== 32'h0) begin miscompares++; $display("FAIL rst_fdata got %0h exp 0", fdata1); end
      start = 1'b1;
      @(negedge clk);
      vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL rst_wins_busy got %0h exp 0", busy1); end
      vectors++; if (we1 !== 1'b0) begin miscompares++; $display("FAIL rst_wins_we got %0h exp 0", we1); end
      rst = 1'b0; start = 1'b0;
   endtask

   task automatic test_clean;
      int bf, bl, bc, dc, dn, wc;
      logic [31:0] w3a, w3b;
      bool_init: begin bf = 0; bl = 0; bc = 0; dc = 0; dn = 0; wc = 0; w3a = '0; w3b = '0; end
      stuck_en = 1'b0;
      observe(140, 0, -1, -1, -1, -1);
      for (int k = 1; k <= 140; k++) begin
         if (busy_h[k]) begin if (bf == 0) bf = k; bl = k; bc++; end
         if (done_h[k]) begin dc = k; dn++; end
         if (we_h[k]) begin
            wc++;
            if (addr_h[k] == 5'd3) begin if (wc <= 32) w3a = din_h[k]; else w3b = din_h[k]; end
         end
      end
      vectors++; if (we_h[1] !== 1'b1 || addr_h[1] !== 5'd0) begin miscompares++; $display("FAIL clean_first_write got we=%0h addr=%0h exp we=1 addr=0", we_h[1], addr_h[1]); end
      vectors++; if (bf != 1) begin miscompares++; $display("FAIL clean_busy_first got %0d exp 1", bf); end
      vectors++; if (bl != 130) begin miscompares++; $display("FAIL clean_busy_last got %0d exp 130", bl); end
      vectors++; if (bc != 130) begin miscompares++; $display("FAIL clean_busy_cnt got %0d exp 130", bc); end
      vectors++; if (dc != 131 || dn != 1) begin miscompares++; $display("FAIL clean_done got cyc=%0d n=%0d exp cyc=131 n=1", dc, dn); end
      vectors++; if (wc != 64) begin miscompares++; $display("FAIL clean_we_cnt got %0d exp 64", wc); end
      vectors++; if (w3a !== 32'hA5A5A5A6) begin miscompares++; $display("FAIL clean_wr0_a3 got %0h exp a5a5a5a6", w3a); end
      vectors++; if (w3b !== 32'h5A5A5A59) begin miscompares++; $display("FAIL clean_wr1_a3 got %0h exp 5a5a5a59", w3b); end
      vectors++; if (we_h[33] !== 1'b0 || addr_h[33] !== 5'd0 || busy_h[33] !== 1'b1) begin miscompares++; $display("FAIL clean_rd0_first got we=%0h addr=%0h exp we=0 addr=0", we_h[33], addr_h[33]); end
      vectors++; if (we_h[65] !== 1'b0 || addr_h[65] !== 5'd31) begin miscompares++; $display("FAIL clean_drain got we=%0h addr=%0h exp we=0 addr=1f", we_h[65], addr_h[65]); end
      vectors++; if (din_h[131] !== 32'h0 || addr_h[131] !== 5'd0) begin miscompares++; $display("FAIL clean_done_port got din=%0h addr=%0h exp 0", din_h[131], addr_h[131]); end
      vectors++; if (pass_h[131] !== 1'b1) begin miscompares++; $display("FAIL clean_pass got %0h exp 1", pass_h[131]); end
      vectors++; if (err_h[131] !== 8'h0) begin miscompares++; $display("FAIL clean_err got %0h exp 0", err_h[131]); end
      vectors++; if (fv_h[131] !== 1'b0) begin miscompares++; $display("FAIL clean_fv got %0h exp 0", fv_h[131]); end
   endtask

   task automatic test_stuck;
      stuck_en = 1'b1;
      observe(140, 0, -1, -1, -1, -1);
      vectors++; if (err_h[41] !== 8'd0) begin miscompares++; $display("FAIL stuck_err_c41 got %0h exp 0", err_h[41]); end
      vectors++; if (err_h[42] !== 8'd1) begin miscompares++; $display("FAIL stuck_err_c42 got %0h exp 1", err_h[42]); end
      vectors++; if (err_h[131] !== 8'd1) begin miscompares++; $display("FAIL stuck_err_final got %0h exp 1", err_h[131]); end
      vectors++; if (pass_h[131] !== 1'b0 || done_h[131] !== 1'b1) begin miscompares++; $display("FAIL stuck_pass got pass=%0h done=%0h exp pass=0 done=1", pass_h[131], done_h[131]); end
      vectors++; if (fv1 !== 1'b1) begin miscompares++; $display("FAIL stuck_fv got %0h exp 1", fv1); end
      vectors++; if (faddr1 !== 5'd7) begin miscompares++; $display("FAIL stuck_faddr got %0h exp 7", faddr1); end
      vectors++; if (fdata1 !== 32'hA5A5A5A3) begin miscompares++; $display("FAIL stuck_fdata got %0h exp a5a5a5a3", fdata1); end
      vectors++; if (err1 !== 8'd1) begin miscompares++; $display("FAIL stuck_err_held got %0h exp 1", err1); end
      stuck_en = 1'b0;
   endtask

   task automatic test_saturate;
      observe(140, 0, -1, -1, -1, -1);
      vectors++; if (err2 !== 4'hF) begin miscompares++; $display("FAIL sat_err got %0h exp f", err2); end
      vectors++; if (faddr2 !== 5'd0 || fdata2 !== 32'h0) begin miscompares++; $display("FAIL sat_first got addr=%0h data=%0h exp 0 0", faddr2, fdata2); end
      vectors++; if (pass2 !== 1'b0 || fv2 !== 1'b1) begin miscompares++; $display("FAIL sat_status got pass=%0h fv=%0h exp pass=0 fv=1", pass2, fv2); end
   endtask

   task automatic test_reset_mid;
      int dn;
      dn = 0;
      observe(140, 0, -1, -1, -1, 40);
      for (int k = 1; k <= 140; k++) if (done_h[k]) dn++;
      vectors++; if (busy_h[40] !== 1'b1) begin miscompares++; $display("FAIL rmid_busy40 got %0h exp 1", busy_h[40]); end
      vectors++; if (busy_h[41] !== 1'b0 || we_h[41] !== 1'b0) begin miscompares++; $display("FAIL rmid_c41 got busy=%0h we=%0h exp 0 0", busy_h[41], we_h[41]); end
      vectors++; if (addr_h[41] !== 5'd0 || din_h[41] !== 32'h0) begin miscompares++; $display("FAIL rmid_port got addr=%0h din=%0h exp 0 0", addr_h[41], din_h[41]); end
      vectors++; if (err_h[41] !== 8'd0 || pass_h[41] !== 1'b0 || fv_h[41] !== 1'b0) begin miscompares++; $display("FAIL rmid_status got err=%0h pass=%0h fv=%0h exp 0", err_h[41], pass_h[41], fv_h[41]); end
      vectors++; if (dn != 0) begin miscompares++; $display("FAIL rmid_no_done got %0d exp 0", dn); end
      observe(140, 0, -1, -1, -1, -1);
      vectors++; if (done_h[131] !== 1'b1 || pass_h[131] !== 1'b1) begin miscompares++; $display("FAIL rmid_rerun got done=%0h pass=%0h exp 1 1", done_h[131], pass_h[131]); end
   endtask

   task automatic test_back_to_back;
      int dn;
      dn = 0;
      stuck_en = 1'b1;
      observe(140, 0, 10, 100, 135, -1);
      for (int k = 1; k <= 134; k++) if (done_h[k]) dn++;
      vectors++; if (done_h[131] !== 1'b1 || dn != 1) begin miscompares++; $display("FAIL b2b_done got d131=%0h n=%0d exp 1 1", done_h[131], dn); end
      vectors++; if (busy_h[130] !== 1'b1 || busy_h[135] !== 1'b0) begin miscompares++; $display("FAIL b2b_busy got c130=%0h c135=%0h exp 1 0", busy_h[130], busy_h[135]); end
      vectors++; if (busy_h[136] !== 1'b1 || we_h[136] !== 1'b1 || addr_h[136] !== 5'd0) begin miscompares++; $display("FAIL b2b_restart got busy=%0h we=%0h addr=%0h exp 1 1 0", busy_h[136], we_h[136], addr_h[136]); end
      vectors++; if (err_h[135] !== 8'd1 || fv_h[135] !== 1'b1) begin miscompares++; $display("FAIL b2b_held got err=%0h fv=%0h exp 1 1", err_h[135], fv_h[135]); end
      vectors++; if (err_h[136] !== 8'd0 || fv_h[136] !== 1'b0) begin miscompares++; $display("FAIL b2b_cleared got err=%0h fv=%0h exp 0 0", err_h[136], fv_h[136]); end
      stuck_en = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stuck_en = 1'b0;
      test_reset;
      test_clean;
      test_stuck;
      test_saturate;
      test_reset_mid;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
